// File: rtl/hpdcache_sync_buffer_rrarb_pkg.sv
// Shared helpers for the round-robin synchronization-buffer arbiter.
// Pointer arithmetic modulo a non-power-of-two requester count lives here.
package hpdcache_sync_buffer_rrarb_pkg;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/hpdcache_rrarb.sv
// Round-robin one-hot grant: first set bit of req scanning from ptr upwards, wrapping at N.
// Purely combinational, zero latency; no backpressure of its own (grant ignores any consumer).
module hpdcache_rrarb #(
    parameter  int unsigned N     = 4,
    localparam int unsigned SRC_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SRC_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    int unsigned k;
    logic        found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        k     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = 32'(ptr) + i;
            if (k >= N) k = k - N;
            if (!found && req[k[SRC_W-1:0]]) begin
                gnt[k[SRC_W-1:0]] = 1'b1;
                found             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hpdcache_sync_buffer_rrarb.sv
// N-to-1 single-slot sync buffer with round-robin write arbitration; beats tagged with source.
// Latency 1 cycle (0 with FEEDTHROUGH); writers stall via wok_o while the slot is full and unread.
module hpdcache_sync_buffer_rrarb
    import hpdcache_sync_buffer_rrarb_pkg::*;
#(
    parameter  int unsigned N           = 4,
    parameter  bit          FEEDTHROUGH = 1'b0,
    parameter  type         data_t      = logic,
    localparam int unsigned SRC_W       = $clog2(N)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [N-1:0]      w_i,
    output logic [N-1:0]      wok_o,
    input  data_t [N-1:0]     wdata_i,
    input  logic              r_i,
    output logic              rok_o,
    output data_t             rdata_o,
    output logic [SRC_W-1:0]  rsrc_o
);

    logic             valid_q;
    data_t            buf_q;
    logic [SRC_W-1:0] src_q;
    logic [SRC_W-1:0] ptr_q;

    logic [N-1:0]     gnt;
    logic [SRC_W-1:0] idx;
    logic             any_gnt;
    logic             acc;
    logic             we;
    logic             valid_d;

    hpdcache_rrarb #(.N(N)) i_rrarb (
        .req (w_i),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt[i]) idx = idx | SRC_W'(i);
        end
    end

    assign any_gnt = |gnt;
    assign acc     = ~valid_q | (FEEDTHROUGH & r_i);
    assign wok_o   = gnt & {N{acc}};

    // With feedthrough, an empty slot read this cycle is bypassed and a full slot read this cycle is replaced.
    assign we      = FEEDTHROUGH ? (any_gnt & ~(valid_q ^ r_i)) : (any_gnt & ~valid_q);
    assign valid_d = we | (valid_q & ~r_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            buf_q   <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            if (we) begin
                buf_q <= wdata_i[idx];
                src_q <= idx;
            end
            if (|wok_o) ptr_q <= SRC_W'(rr_next(32'(idx), N));
        end
    end

    assign rok_o = valid_q | (FEEDTHROUGH & any_gnt);

    always_comb begin
        if (FEEDTHROUGH && !valid_q) begin
            rdata_o = wdata_i[idx];
            rsrc_o  = idx;
        end else begin
            rdata_o = buf_q;
            rsrc_o  = src_q;
        end
    end

endmodule

// File: tb/tb_hpdcache_sync_buffer_rrarb.sv
// Two instances (plain and feedthrough) driven by random requesters/reader, scored against a queue model.
module tb_hpdcache_sync_buffer_rrarb;

    typedef struct {
        int src;
        int dat;
        int cyc;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic [3:0]      w     [2];
    logic [3:0]      wok   [2];
    logic [3:0][7:0] wdata [2];
    logic            r     [2];
    logic            rok   [2];
    logic [7:0]      rdata [2];
    logic [1:0]      rsrc  [2];

    always #5 clk = ~clk;

    hpdcache_sync_buffer_rrarb #(.N(4), .FEEDTHROUGH(1'b0), .data_t(logic [7:0])) dut_nf (
        .clk_i(clk), .rst_ni(rst_ni), .w_i(w[0]), .wok_o(wok[0]), .wdata_i(wdata[0]),
        .r_i(r[0]), .rok_o(rok[0]), .rdata_o(rdata[0]), .rsrc_o(rsrc[0])
    );

    hpdcache_sync_buffer_rrarb #(.N(4), .FEEDTHROUGH(1'b1), .data_t(logic [7:0])) dut_ft (
        .clk_i(clk), .rst_ni(rst_ni), .w_i(w[1]), .wok_o(wok[1]), .wdata_i(wdata[1]),
        .r_i(r[1]), .rok_o(rok[1]), .rdata_o(rdata[1]), .rsrc_o(rsrc[1])
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         in_rst = 1'b1;
    bit         active [2][4];
    logic [7:0] rdat   [2][4];
    int         ptr_m  [2];
    beat_t      q0[$];
    beat_t      q1[$];

    logic [3:0] mask;
    int         req_pct;
    int         r_pct;
    bit         fixed;

    task automatic chk(input string name, input int inst, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h expected=%0h", name, inst, cyc, act, exp);
        end
    endtask

    function automatic int qsz(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic beat_t qhead(input int i);
        if (i == 0) return q0[0];
        return q1[0];
    endfunction

    task automatic qpush(input int i, input beat_t b);
        if (i == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    task automatic qpop(input int i);
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    // Reference: the slot is the queue of accepted-but-unread beats; grant is the first
    // requester at or after the pointer, accepted when the slot is free (or read, with feedthrough).
    task automatic model(input int i);
        int    g;
        int    k;
        bit    acc;
        int    ew;
        beat_t b;
        acc = (qsz(i) == 0) || (i == 1 && r[i]);
        g = -1;
        for (int s = 0; s < 4; s++) begin
            k = (ptr_m[i] + s) % 4;
            if (g < 0 && w[i][k]) g = k;
        end
        ew = (g >= 0 && acc) ? (1 << g) : 0;
        chk("wok", i, int'(wok[i]), ew);
        if (ew != 0) begin
            b.src = g;
            b.dat = int'(rdat[i][g]);
            b.cyc = cyc;
            qpush(i, b);
            active[i][g] = 1'b0;
            ptr_m[i] = (g + 1) % 4;
        end
    endtask

    always @(negedge clk) begin
        if (!in_rst) begin
            for (int i = 0; i < 2; i++) begin
                bit    vis;
                beat_t h;
                vis = 1'b0;
                h = '{0, 0, 0};
                if (qsz(i) > 0) begin
                    h = qhead(i);
                    vis = (i == 1) || (h.cyc < cyc);
                end
                chk("rok", i, int'(rok[i]), int'(vis));
                if (vis) begin
                    chk("rdata", i, int'(rdata[i]), h.dat);
                    chk("rsrc", i, int'(rsrc[i]), h.src);
                    if (r[i]) qpop(i);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        rst_ni = 1'b1;
        in_rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            r[i] = ($urandom_range(0, 99) < r_pct);
            for (int k = 0; k < 4; k++) begin
                if (!active[i][k] && mask[k] && ($urandom_range(0, 99) < req_pct)) begin
                    active[i][k] = 1'b1;
                    rdat[i][k] = fixed ? (8'hA0 + 8'(k)) : 8'($urandom);
                end
                w[i][k] = active[i][k];
                wdata[i][k] = rdat[i][k];
            end
        end
        #2;
        for (int i = 0; i < 2; i++) model(i);
    endtask

    task automatic run(input int n, input logic [3:0] m, input int rq, input int rr, input bit fx);
        mask = m;
        req_pct = rq;
        r_pct = rr;
        fixed = fx;
        repeat (n) step();
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        in_rst = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #3;
            chk("rst_rok_nf", 0, int'(rok[0]), 0);
            chk("rst_rok_ft", 1, int'(rok[1]), int'(|w[1]));
            chk("rst_rdata_nf", 0, int'(rdata[0]), 0);
            chk("rst_rsrc_nf", 0, int'(rsrc[0]), 0);
        end
        q0.delete();
        q1.delete();
        ptr_m[0] = 0;
        ptr_m[1] = 0;
    endtask

    initial begin
        mask = 4'hF;
        req_pct = 100;
        r_pct = 100;
        fixed = 1'b1;
        for (int i = 0; i < 2; i++) begin
            r[i] = 1'b1;
            ptr_m[i] = 0;
            for (int k = 0; k < 4; k++) begin
                active[i][k] = 1'b1;
                rdat[i][k] = 8'hA0 + 8'(k);
                w[i][k] = 1'b1;
                wdata[i][k] = rdat[i][k];
            end
        end

        do_reset(3);
        run(40, 4'hF, 100, 100, 1'b1);
        run(30, 4'b0101, 100, 100, 1'b1);
        run(300, 4'hF, 40, 50, 1'b0);
        run(10, 4'hF, 60, 0, 1'b0);
        run(20, 4'hF, 60, 100, 1'b0);
        run(5, 4'hF, 100, 0, 1'b0);
        do_reset(1);
        run(300, 4'hF, 50, 60, 1'b0);
        run(30, 4'h0, 0, 100, 1'b0);
        chk("drain_nf", 0, q0.size(), 0);
        chk("drain_ft", 1, q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
